// File: rtl/pu_window_gen.sv
// pu_window_gen: img2col unit that assembles a KxK window from dual-port pixel writes and
// reuses the overlapping columns across slides. Define PU_NEIGHBOUR_OUT_EN to publish them.
module pu_window_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int K          = 5,
    parameter int STRIDE     = 1,
    parameter int ADDR_W     = $clog2(K * K)
) (
    input  logic                                  clk,
    input  logic                                  nrst,
    input  logic                                  start,
    input  logic                                  round,
    input  logic                                  wr_en1,
    input  logic                                  wr_en2,
    input  logic [ADDR_W-1:0]                     adrs_in1,
    input  logic [ADDR_W-1:0]                     adrs_in2,
    input  logic [DATA_WIDTH-1:0]                 new1,
    input  logic [DATA_WIDTH-1:0]                 new2,
    output logic [K*K*DATA_WIDTH-1:0]             win_data,
    output logic                                  win_valid,
    input  logic                                  win_ready,
    output logic [(K-STRIDE)*K*DATA_WIDTH-1:0]    neighbour_out,
    output logic                                  neighbour_out_flag,
    output logic                                  busy,
    output logic                                  err
);
    localparam int N     = K * K;
    localparam int RESV  = (K - STRIDE) * K;
    localparam int SHIFT = STRIDE * K;
    localparam logic [ADDR_W:0] N_A    = (ADDR_W + 1)'(N);
    localparam logic [ADDR_W:0] RESV_A = (ADDR_W + 1)'(RESV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] win_q     [N];
    logic [DATA_WIDTH-1:0] win_d     [N];
    logic [DATA_WIDTH-1:0] shift_src [N];
    logic [N-1:0]          loaded_q, loaded_d;
    logic [N-1:0]          req_mask, hit1, hit2;
    logic                  incr_q, incr_d;
    logic                  resv_ok_q, resv_ok_d;
    logic                  err_q, err_d;
    logic                  start_fire, start_incr, start_err;
    logic                  in_load, hs, done;
    logic                  bad1, bad2, ok1, ok2;

    genvar gi;

    assign start_fire = (state_q == IDLE) && start;
    assign start_incr = start_fire && round && resv_ok_q;
    assign start_err  = start_fire && round && !resv_ok_q;
    assign in_load    = (state_q == LOAD);

    // Incremental loads may only touch the freshly shifted-in columns.
    assign bad1 = in_load && wr_en1 &&
                  (({1'b0, adrs_in1} >= N_A) || (incr_q && ({1'b0, adrs_in1} < RESV_A)));
    assign bad2 = in_load && wr_en2 &&
                  (({1'b0, adrs_in2} >= N_A) || (incr_q && ({1'b0, adrs_in2} < RESV_A)));
    assign ok1  = in_load && wr_en1 && !bad1;
    assign ok2  = in_load && wr_en2 && !bad2;

    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            assign hit1[gi]     = ok1 && (adrs_in1 == ADDR_W'(gi));
            assign hit2[gi]     = ok2 && (adrs_in2 == ADDR_W'(gi));
            assign req_mask[gi] = (gi >= RESV) ? 1'b1 : !incr_q;
            if (gi < RESV) begin : g_shift
                assign shift_src[gi] = win_q[gi + SHIFT];
            end else begin : g_keep
                assign shift_src[gi] = win_q[gi];
            end
            assign win_data[gi*DATA_WIDTH +: DATA_WIDTH] = win_q[gi];
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < N; i++) begin
            win_d[i]    = win_q[i];
            loaded_d[i] = loaded_q[i];
            if (start_fire && !start_incr) begin
                loaded_d[i] = 1'b0;
            end
            if (hit2[i]) begin
                win_d[i]    = new2;
                loaded_d[i] = 1'b1;
            end else if (hit1[i]) begin
                win_d[i]    = new1;
                loaded_d[i] = 1'b1;
            end
            if (hs) begin
                win_d[i] = shift_src[i];
                if (i >= RESV) begin
                    loaded_d[i] = 1'b0;
                end
            end
        end
    end

    assign done      = &(loaded_d | ~req_mask);
    assign incr_d    = start_fire ? start_incr : incr_q;
    assign resv_ok_d = resv_ok_q | hs;
    assign err_d     = start_err | bad1 | bad2;
    assign err       = err_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = LOAD;
            LOAD:    if (done)      state_d = EMIT;
            EMIT:    if (win_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        win_valid = 1'b0;
        busy      = 1'b0;
        hs        = 1'b0;
        case (state_q)
            LOAD: busy = 1'b1;
            EMIT: begin
                busy      = 1'b1;
                win_valid = 1'b1;
                hs        = win_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < N; i++) begin
                win_q[i] <= '0;
            end
            loaded_q  <= '0;
            incr_q    <= 1'b0;
            resv_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                win_q[i] <= win_d[i];
            end
            loaded_q  <= loaded_d;
            incr_q    <= incr_d;
            resv_ok_q <= resv_ok_d;
            err_q     <= err_d;
        end
    end

`ifdef PU_NEIGHBOUR_OUT_EN
    logic [DATA_WIDTH-1:0] nb_q [RESV];
    logic                  nb_flag_q;

    // Captures the post-shift low columns, i.e. the pre-shift columns STRIDE..K-1.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int j = 0; j < RESV; j++) begin
                nb_q[j] <= '0;
            end
            nb_flag_q <= 1'b0;
        end else begin
            nb_flag_q <= hs;
            if (hs) begin
                for (int j = 0; j < RESV; j++) begin
                    nb_q[j] <= shift_src[j];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < RESV; gi++) begin : g_nb
            assign neighbour_out[gi*DATA_WIDTH +: DATA_WIDTH] = nb_q[gi];
        end
    endgenerate
    assign neighbour_out_flag = nb_flag_q;
`else
    assign neighbour_out      = '0;
    assign neighbour_out_flag = 1'b0;
`endif

endmodule

// File: tb/tb_pu_window_gen.sv
// Scoreboard bench for pu_window_gen (K=5, STRIDE=1): directed loads, errors,
// collisions, backpressure and mid-load reset.
module tb_pu_window_gen;
    localparam int DW    = 16;
    localparam int K     = 5;
    localparam int N     = K * K;
    localparam int WIN_W = N * DW;
    localparam int NB_W  = (K - 1) * K * DW;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              start = 1'b0;
    logic              round = 1'b0;
    logic              wr_en1 = 1'b0;
    logic              wr_en2 = 1'b0;
    logic [4:0]        adrs_in1 = '0;
    logic [4:0]        adrs_in2 = '0;
    logic [DW-1:0]     new1 = '0;
    logic [DW-1:0]     new2 = '0;
    logic [WIN_W-1:0]  win_data;
    logic              win_valid;
    logic              win_ready = 1'b0;
    logic [NB_W-1:0]   neighbour_out;
    logic              neighbour_out_flag;
    logic              busy;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int win_cnt = 0;
    logic [WIN_W-1:0] exp_win_q [$];
    logic [WIN_W-1:0] exp_nb_q [$];
    logic [WIN_W-1:0] last_nb = '0;
    logic [DW-1:0]    model [N];

    pu_window_gen #(.DATA_WIDTH(DW), .K(K), .STRIDE(1)) dut (
        .clk(clk), .nrst(nrst), .start(start), .round(round),
        .wr_en1(wr_en1), .wr_en2(wr_en2), .adrs_in1(adrs_in1), .adrs_in2(adrs_in2),
        .new1(new1), .new2(new2), .win_data(win_data), .win_valid(win_valid),
        .win_ready(win_ready), .neighbour_out(neighbour_out),
        .neighbour_out_flag(neighbour_out_flag), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIN_W-1:0] act,
                         input logic [WIN_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIN_W-1:0] pack_win();
        logic [WIN_W-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = model[i];
        return v;
    endfunction

    function automatic logic [WIN_W-1:0] pack_nb();
        logic [WIN_W-1:0] v = '0;
        for (int i = 0; i < N - K; i++) v[i*DW +: DW] = model[i + K];
        return v;
    endfunction

    // Monitor: pops expectations whenever the DUT hands over a window or neighbour block.
    always @(negedge clk) begin
        logic [WIN_W-1:0] e;
        if (nrst) begin
            if (win_valid && win_ready) begin
                win_cnt++;
                $display("window %0d accepted: %h", win_cnt, win_data);
                if (exp_win_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL win_unexpected: got a window, expected none");
                end else begin
                    e = exp_win_q.pop_front();
                    check("window", win_data, e);
                end
            end
            if (neighbour_out_flag) begin
                if (exp_nb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL nb_unexpected: got flag=1, expected no neighbour pulse");
                end else begin
                    e = exp_nb_q.pop_front();
                    check("neighbour", WIN_W'(neighbour_out), e);
                end
            end
            if (err) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit r);
        start = 1'b1; round = r;
        tick();
        start = 1'b0; round = 1'b0;
    endtask

    task automatic wr(input bit e1, input int a1, input int d1,
                      input bit e2, input int a2, input int d2);
        wr_en1 = e1; adrs_in1 = a1[4:0]; new1 = d1[DW-1:0];
        wr_en2 = e2; adrs_in2 = a2[4:0]; new2 = d2[DW-1:0];
        tick();
        wr_en1 = 1'b0; wr_en2 = 1'b0;
    endtask

    // Entry i <= base+i, two per cycle; optionally an out-of-range write on the last cycle.
    task automatic full_load(input int base, input bit bad_last);
        for (int c = 0; c < 13; c++) begin
            if (c == 12) check("valid_before_last", win_valid, 1'b0);
            model[2*c] = DW'(base + 2*c);
            if (c < 12) begin
                model[2*c+1] = DW'(base + 2*c + 1);
                wr(1, 2*c, base + 2*c, 1, 2*c + 1, base + 2*c + 1);
            end else begin
                wr(1, 24, base + 24, bad_last, 25, 16'hDEAD);
            end
        end
        check("valid_after_last", win_valid, 1'b1);
    endtask

    task automatic expect_window();
        exp_win_q.push_back(pack_win());
`ifdef PU_NEIGHBOUR_OUT_EN
        exp_nb_q.push_back(pack_nb());
        last_nb = pack_nb();
`endif
        for (int i = 0; i < N - K; i++) model[i] = model[i + K];
    endtask

    task automatic accept();
        int k = 0;
        while (!win_valid && k < 20) begin
            tick();
            k++;
        end
        check("valid_before_accept", win_valid, 1'b1);
        if (win_valid) begin
            win_ready = 1'b1;
            tick();
            win_ready = 1'b0;
            check("valid_after_hs", win_valid, 1'b0);
            check("busy_after_hs", busy, 1'b0);
`ifdef PU_NEIGHBOUR_OUT_EN
            check("nb_flag_pulse", neighbour_out_flag, 1'b1);
`else
            check("nb_flag_off", neighbour_out_flag, 1'b0);
`endif
            tick();
            check("nb_flag_drop", neighbour_out_flag, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) model[i] = '0;
        #1;
        check("rst_win_data", win_data, '0);
        check("rst_valid", win_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_nb", WIN_W'(neighbour_out), '0);
        check("rst_nb_flag", neighbour_out_flag, 1'b0);
        tick();
        nrst = 1'b1;
        tick();

        // Full load; round=1 straight after reset is an error and falls back to full.
        do_start(1);
        check("err_bad_start", err, 1'b1);
        check("busy_after_start", busy, 1'b1);
        full_load(1, 1);
        check("err_addr25", err, 1'b1);
        expect_window();
        accept();
        check("err_count_t1", err_cnt, 2);

        // Incremental load of column 4; write to entry 3 is rejected.
        do_start(1);
        check("no_err_incr_start", err, 1'b0);
        wr(1, 3, 16'hBEEF, 1, 20, 100);
        check("err_low_addr", err, 1'b1);
        model[20] = 16'd100;
        wr(1, 21, 101, 1, 22, 102);
        check("incr_valid_early", win_valid, 1'b0);
        model[21] = 16'd101; model[22] = 16'd102;
        wr(1, 23, 103, 1, 24, 104);
        check("incr_valid", win_valid, 1'b1);
        model[23] = 16'd103; model[24] = 16'd104;
        expect_window();
        accept();

        // Same-address collision, then 10 cycles of backpressure with writes and start.
        do_start(0);
        wr(1, 7, 16'hAAAA, 1, 7, 16'h5555);
        model[7] = 16'h5555;
        begin
            int addrs[$];
            for (int i = 0; i < N; i++) if (i != 7) addrs.push_back(i);
            for (int c = 0; c < 12; c++) begin
                if (c == 11) check("coll_valid_early", win_valid, 1'b0);
                model[addrs[2*c]]   = DW'(16'h1000 + addrs[2*c]);
                model[addrs[2*c+1]] = DW'(16'h1000 + addrs[2*c+1]);
                wr(1, addrs[2*c], 16'h1000 + addrs[2*c], 1, addrs[2*c+1], 16'h1000 + addrs[2*c+1]);
            end
        end
        for (int h = 0; h < 10; h++) begin
            start = 1'b1;
            wr_en1 = 1'b1; adrs_in1 = 5'd7; new1 = 16'hFFFF;
            wr_en2 = 1'b1; adrs_in2 = 5'd8; new2 = 16'hFFFF;
            tick();
            check("hold_valid", win_valid, 1'b1);
            check("hold_data", win_data, pack_win());
            check("hold_no_err", err, 1'b0);
        end
        start = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0;
        expect_window();
        accept();
        check("err_count_t3", err_cnt, 3);

        // Reset in the middle of a load.
        do_start(0);
        for (int c = 0; c < 5; c++) wr(1, 2*c, 16'h2000 + 2*c, 1, 2*c + 1, 16'h2001 + 2*c);
        #2 nrst = 1'b0;
        #1;
        check("mid_rst_win_data", win_data, '0);
        check("mid_rst_valid", win_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_nb", WIN_W'(neighbour_out), '0);
        tick();
        nrst = 1'b1;
        for (int i = 0; i < N; i++) model[i] = '0;
        last_nb = '0;
        tick();
        do_start(1);
        check("err_after_rst", err, 1'b1);
        full_load(16'h3000, 0);
        expect_window();
        accept();

        tick();
        check("err_count_total", err_cnt, 4);
        check("win_queue_empty", exp_win_q.size(), 0);
        check("nb_queue_empty", exp_nb_q.size(), 0);
        check("final_nb", WIN_W'(neighbour_out), last_nb);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
